// File: rtl/sap_pkg.sv
// Shared constants for the SAP control sequencer: opcodes, control-word bit positions
// and the sequencer state encoding.
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bit positions inside the 15-bit control word; n-prefixed bits are active low.
  localparam int unsigned CTRL_CP   = 14;
  localparam int unsigned CTRL_EP   = 13;
  localparam int unsigned CTRL_LP   = 12;
  localparam int unsigned CTRL_NLMA = 11;
  localparam int unsigned CTRL_NLMD = 10;
  localparam int unsigned CTRL_NCE  = 9;
  localparam int unsigned CTRL_NLR  = 8;
  localparam int unsigned CTRL_NLI  = 7;
  localparam int unsigned CTRL_NEI  = 6;
  localparam int unsigned CTRL_NLA  = 5;
  localparam int unsigned CTRL_EA   = 4;
  localparam int unsigned CTRL_SUB  = 3;
  localparam int unsigned CTRL_EU   = 2;
  localparam int unsigned CTRL_NLB  = 1;
  localparam int unsigned CTRL_NLO  = 0;

  localparam logic [14:0] CTRL_IDLE = 15'h0FE3;

  typedef enum logic [2:0] {
    StRun,
    StHalt,
    StPclr,
    StPaddr,
    StPwait,
    StPdata,
    StPwrite,
    StPdone
  } state_e;

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: maps (opcode, micro-step, flags) to the control word and flags
// the last active micro-step of the instruction.
module sap_microcode_rom
  import sap_pkg::*;
(
  input  logic [3:0]  opcode_i,
  input  logic [2:0]  t_state_i,
  input  logic        cf_i,
  input  logic        zf_i,
  output logic [14:0] ctrl_o,
  output logic        last_step_o
);

  always_comb begin
    ctrl_o      = CTRL_IDLE;
    last_step_o = 1'b0;
    case (t_state_i)
      3'd0: begin
        ctrl_o[CTRL_EP]   = 1'b1;
        ctrl_o[CTRL_NLMA] = 1'b0;
      end
      3'd1: begin
        ctrl_o[CTRL_CP]  = 1'b1;
        ctrl_o[CTRL_NCE] = 1'b0;
        ctrl_o[CTRL_NLI] = 1'b0;
        // Only opcodes with an execute phase continue past T1; unknown ones act as NOP.
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
          OP_JMP, OP_JC, OP_JZ, OP_OUT: last_step_o = 1'b0;
          default:                      last_step_o = 1'b1;
        endcase
      end
      3'd2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_o[CTRL_NEI]  = 1'b0;
            ctrl_o[CTRL_NLMA] = 1'b0;
          end
          OP_LDI: begin
            ctrl_o[CTRL_NEI] = 1'b0;
            ctrl_o[CTRL_NLA] = 1'b0;
            last_step_o      = 1'b1;
          end
          OP_JMP: begin
            ctrl_o[CTRL_NEI] = 1'b0;
            ctrl_o[CTRL_LP]  = 1'b1;
            last_step_o      = 1'b1;
          end
          OP_JC: begin
            ctrl_o[CTRL_NEI] = 1'b0;
            ctrl_o[CTRL_LP]  = cf_i;
            last_step_o      = 1'b1;
          end
          OP_JZ: begin
            ctrl_o[CTRL_NEI] = 1'b0;
            ctrl_o[CTRL_LP]  = zf_i;
            last_step_o      = 1'b1;
          end
          OP_OUT: begin
            ctrl_o[CTRL_EA]  = 1'b1;
            ctrl_o[CTRL_NLO] = 1'b0;
            last_step_o      = 1'b1;
          end
          default: ;
        endcase
      end
      3'd3: begin
        case (opcode_i)
          OP_LDA: begin
            ctrl_o[CTRL_NCE] = 1'b0;
            ctrl_o[CTRL_NLA] = 1'b0;
            last_step_o      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_o[CTRL_NCE] = 1'b0;
            ctrl_o[CTRL_NLB] = 1'b0;
            ctrl_o[CTRL_SUB] = (opcode_i == OP_SUB);
          end
          OP_STA: begin
            ctrl_o[CTRL_EA]   = 1'b1;
            ctrl_o[CTRL_NLMD] = 1'b0;
          end
          default: ;
        endcase
      end
      3'd4: begin
        case (opcode_i)
          OP_ADD, OP_SUB: begin
            ctrl_o[CTRL_EU]  = 1'b1;
            ctrl_o[CTRL_NLA] = 1'b0;
            ctrl_o[CTRL_SUB] = (opcode_i == OP_SUB);
            last_step_o      = 1'b1;
          end
          OP_STA: begin
            ctrl_o[CTRL_NLR] = 1'b0;
            last_step_o      = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// Control sequencer for the bus-based 8-bit CPU: micro-step FSM, halt, and the
// host programming handshake that fills all 2^ADDR_W RAM bytes.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned T_STATES  = 6,
  parameter int unsigned EARLY_END = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        CF,
  input  logic        ZF,
  input  logic        programming,
  input  logic        ui_valid,
  output logic [14:0] ctrl,
  output logic        pc_clr,
  output logic        read_ui_in,
  output logic        ready,
  output logic        done_load,
  output logic        HF,
  output logic [2:0]  t_state
);

  localparam logic [2:0]        TLast  = 3'(T_STATES - 1);
  localparam logic [ADDR_W-1:0] CntMax = '1;

  state_e            state_q, state_d;
  logic [2:0]        t_q, t_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pc_clr_q, pc_clr_d;
  logic              read_ui_in_q, read_ui_in_d;
  logic              ready_q, ready_d;
  logic              done_load_q, done_load_d;
  logic              hf_q, hf_d;

  logic [14:0] rom_ctrl;
  logic        rom_last;
  logic        load_req;

  sap_microcode_rom u_rom (
    .opcode_i    (opcode),
    .t_state_i   (t_q),
    .cf_i        (CF),
    .zf_i        (ZF),
    .ctrl_o      (rom_ctrl),
    .last_step_o (rom_last)
  );

  assign load_req = (state_q == StRun) && (t_q == 3'd0) && programming;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRun: begin
        if (load_req) begin
          state_d = StPclr;
        end else if ((t_q == 3'd1) && (opcode == OP_HLT)) begin
          state_d = StHalt;
          t_d     = 3'd0;
        end else if (((EARLY_END != 0) && rom_last) || (t_q == TLast)) begin
          t_d = 3'd0;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      StHalt:  state_d = StHalt;
      StPclr:  state_d = StPaddr;
      StPaddr: state_d = StPwait;
      StPwait: if (ui_valid) state_d = StPdata;
      StPdata: state_d = StPwrite;
      StPwrite: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CntMax) ? StPdone : StPaddr;
      end
      StPdone: if (!programming) state_d = StRun;
      default: state_d = StRun;
    endcase

    // Status outputs are registered from the next state so they line up with state_q.
    pc_clr_d     = (state_d == StPclr) || (state_d == StPdone);
    read_ui_in_d = (state_d == StPdata);
    ready_d      = (state_d == StPwait);
    done_load_d  = (state_d == StPdone);
    hf_d         = (state_d == StHalt);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      t_q          <= 3'd0;
      cnt_q        <= '0;
      pc_clr_q     <= 1'b0;
      read_ui_in_q <= 1'b0;
      ready_q      <= 1'b0;
      done_load_q  <= 1'b0;
      hf_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      cnt_q        <= cnt_d;
      pc_clr_q     <= pc_clr_d;
      read_ui_in_q <= read_ui_in_d;
      ready_q      <= ready_d;
      done_load_q  <= done_load_d;
      hf_q         <= hf_d;
    end
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state_q)
      StRun: if (!load_req) ctrl = rom_ctrl;
      StPaddr: begin
        ctrl[CTRL_EP]   = 1'b1;
        ctrl[CTRL_NLMA] = 1'b0;
      end
      StPdata: ctrl[CTRL_NLMD] = 1'b0;
      StPwrite: begin
        ctrl[CTRL_NLR] = 1'b0;
        ctrl[CTRL_CP]  = 1'b1;
      end
      default: ;
    endcase
    // Reset state is RUN/T0, whose fetch word must not reach the bus while reset is held.
    if (!rst_n) ctrl = CTRL_IDLE;
  end

  assign pc_clr     = pc_clr_q;
  assign read_ui_in = read_ui_in_q;
  assign ready      = ready_q;
  assign done_load  = done_load_q;
  assign HF         = hf_q;
  assign t_state    = t_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: per-opcode vector table plus hand-written
// sequences for reset, halt, program load and the fixed-length variant.
module tb_sap_control_sequencer;

  localparam logic [14:0] C_IDLE  = 15'h0FE3;
  localparam logic [14:0] C_T0    = 15'h27E3;
  localparam logic [14:0] C_T1    = 15'h4D63;
  localparam logic [14:0] C_MAR   = 15'h07A3;
  localparam logic [14:0] C_PDATA = 15'h0BE3;
  localparam logic [14:0] C_PWR   = 15'h4EE3;

  typedef struct {
    logic [3:0]  op;
    logic        cf;
    logic        zf;
    int          len;
    logic [14:0] c2;
    logic [14:0] c3;
    logic [14:0] c4;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, rst_n0;
  logic [3:0]  opcode, op0;
  logic        cf, zf, programming, ui_valid;
  logic [14:0] ctrl, ctrl0;
  logic        pc_clr, read_ui_in, ready, done_load, hf;
  logic [2:0]  t_state;
  logic        pc_clr0, read_ui_in0, ready0, done_load0, hf0;
  logic [2:0]  t_state0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   nlr_pulses = 0;
  logic count_en = 1'b0;
  vec_t vecs[15];

  always #5 clk = ~clk;

  always @(posedge clk) if (count_en && !ctrl[8]) nlr_pulses++;

  sap_control_sequencer #(.ADDR_W(4), .T_STATES(6), .EARLY_END(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .CF          (cf),
    .ZF          (zf),
    .programming (programming),
    .ui_valid    (ui_valid),
    .ctrl        (ctrl),
    .pc_clr      (pc_clr),
    .read_ui_in  (read_ui_in),
    .ready       (ready),
    .done_load   (done_load),
    .HF          (hf),
    .t_state     (t_state)
  );

  sap_control_sequencer #(.ADDR_W(4), .T_STATES(6), .EARLY_END(0)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n0),
    .opcode      (op0),
    .CF          (cf),
    .ZF          (zf),
    .programming (1'b0),
    .ui_valid    (ui_valid),
    .ctrl        (ctrl0),
    .pc_clr      (pc_clr0),
    .read_ui_in  (read_ui_in0),
    .ready       (ready0),
    .done_load   (done_load0),
    .HF          (hf0),
    .t_state     (t_state0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input int exp_len);
    int n;
    opcode = op;
    n = 0;
    do begin
      tick();
      n++;
    end while (t_state != 3'd0 && n < 12);
    check($sformatf("len_op%0h", op), n, exp_len);
  endtask

  initial begin
    rst_n = 1'b0; rst_n0 = 1'b0; opcode = 4'h0; op0 = 4'h0;
    cf = 1'b0; zf = 1'b0; programming = 1'b0; ui_valid = 1'b0;

    vecs[0]  = '{4'h0, 1'b0, 1'b0, 2, C_IDLE,    C_IDLE,    C_IDLE};
    vecs[1]  = '{4'h1, 1'b0, 1'b0, 4, C_MAR,     15'h0DC3,  C_IDLE};
    vecs[2]  = '{4'h2, 1'b0, 1'b0, 5, C_MAR,     15'h0DE1,  15'h0FC7};
    vecs[3]  = '{4'h3, 1'b0, 1'b0, 5, C_MAR,     15'h0DE9,  15'h0FCF};
    vecs[4]  = '{4'h4, 1'b0, 1'b0, 5, C_MAR,     15'h0BF3,  15'h0EE3};
    vecs[5]  = '{4'h5, 1'b0, 1'b0, 3, 15'h0F83,  C_IDLE,    C_IDLE};
    vecs[6]  = '{4'h6, 1'b0, 1'b0, 3, 15'h1FA3,  C_IDLE,    C_IDLE};
    vecs[7]  = '{4'h7, 1'b0, 1'b1, 3, 15'h0FA3,  C_IDLE,    C_IDLE};
    vecs[8]  = '{4'h7, 1'b1, 1'b0, 3, 15'h1FA3,  C_IDLE,    C_IDLE};
    vecs[9]  = '{4'h8, 1'b1, 1'b0, 3, 15'h0FA3,  C_IDLE,    C_IDLE};
    vecs[10] = '{4'h8, 1'b0, 1'b1, 3, 15'h1FA3,  C_IDLE,    C_IDLE};
    vecs[11] = '{4'hE, 1'b0, 1'b0, 3, 15'h0FF2,  C_IDLE,    C_IDLE};
    vecs[12] = '{4'hB, 1'b0, 1'b0, 2, C_IDLE,    C_IDLE,    C_IDLE};
    vecs[13] = '{4'hC, 1'b1, 1'b1, 2, C_IDLE,    C_IDLE,    C_IDLE};
    vecs[14] = '{4'h9, 1'b0, 1'b0, 2, C_IDLE,    C_IDLE,    C_IDLE};

    // Reset values while reset is held
    #3;
    check("rst_ctrl", ctrl, C_IDLE);
    check("rst_t", t_state, 3'd0);
    check("rst_flags", {pc_clr, read_ui_in, ready, done_load, hf}, 5'b0);

    // Per-opcode micro-step table
    for (int i = 0; i < 15; i++) begin
      opcode = vecs[i].op; cf = vecs[i].cf; zf = vecs[i].zf;
      do_reset();
      check($sformatf("op%0h_t0_ctrl", vecs[i].op), ctrl, C_T0);
      for (int s = 1; s < vecs[i].len; s++) begin
        logic [14:0] exp;
        tick();
        exp = (s == 1) ? C_T1 : (s == 2) ? vecs[i].c2 : (s == 3) ? vecs[i].c3 : vecs[i].c4;
        check($sformatf("op%0h_t%0d_state", vecs[i].op, s), t_state, s);
        check($sformatf("op%0h_t%0d_ctrl", vecs[i].op, s), ctrl, exp);
      end
      tick();
      check($sformatf("op%0h_wrap_t", vecs[i].op), t_state, 3'd0);
      check($sformatf("op%0h_wrap_ctrl", vecs[i].op), ctrl, C_T0);
    end
    cf = 1'b0; zf = 1'b0;

    // Asynchronous reset in the middle of ADD T3
    opcode = 4'h2;
    do_reset();
    tick(); tick(); tick();
    check("add_t3_ctrl", ctrl, 15'h0DE1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", ctrl, C_IDLE);
    check("async_rst_t", t_state, 3'd0);
    do_reset();

    // LDI 5; ADD; OUT; HLT program timing
    run_instr(4'h5, 3);
    run_instr(4'h2, 5);
    run_instr(4'hE, 3);
    opcode = 4'hF;
    tick();
    check("hlt_t1_ctrl", ctrl, C_T1);
    tick();
    check("hlt_hf", hf, 1'b1);
    check("hlt_ctrl", ctrl, C_IDLE);
    opcode = 4'h0;
    repeat (4) tick();
    check("hlt_hf_sticky", hf, 1'b1);
    check("hlt_ctrl_sticky", ctrl, C_IDLE);

    // programming raised mid-instruction waits for T0
    opcode = 4'h1;
    do_reset();
    tick();
    programming = 1'b1;
    #1;
    check("midprog_t1_ctrl", ctrl, C_T1);
    tick();
    check("midprog_t2_ctrl", ctrl, C_MAR);
    check("midprog_t2_pcclr", pc_clr, 1'b0);
    tick(); tick();
    check("midprog_t0_t", t_state, 3'd0);
    check("midprog_t0_suppressed", ctrl, C_IDLE);
    tick();
    check("midprog_pclr", pc_clr, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midprog_abort", {pc_clr, ready, done_load}, 3'b0);
    programming = 1'b0;

    // Full 16-byte load with 0/3-cycle valid delays
    opcode = 4'h0;
    do_reset();
    programming = 1'b1;
    #1;
    check("load_t0_suppressed", ctrl, C_IDLE);
    count_en = 1'b1;
    tick();
    check("load_pclr", pc_clr, 1'b1);
    for (int b = 0; b < 16; b++) begin
      tick();
      check($sformatf("load%0d_paddr", b), ctrl, C_T0);
      if (b == 5) programming = 1'b0;
      if (b == 10) programming = 1'b1;
      if (b % 2 == 0) ui_valid = 1'b1;
      tick();
      check($sformatf("load%0d_ready", b), ready, 1'b1);
      if (b % 2 == 1) begin
        repeat (3) begin
          tick();
          check($sformatf("load%0d_wait", b), ready, 1'b1);
        end
        ui_valid = 1'b1;
      end
      tick();
      ui_valid = 1'b0;
      check($sformatf("load%0d_pdata", b), {ready, read_ui_in, ctrl}, {2'b01, C_PDATA});
      tick();
      check($sformatf("load%0d_pwrite", b), {read_ui_in, done_load, ctrl}, {2'b00, C_PWR});
    end
    tick();
    check("load_done", {done_load, pc_clr}, 2'b11);
    check("load_done_ctrl", ctrl, C_IDLE);
    tick();
    check("load_done_hold", done_load, 1'b1);
    count_en = 1'b0;
    check("load_nlr_pulses", nlr_pulses, 16);
    programming = 1'b0;
    tick();
    check("load_exit_flags", {done_load, pc_clr}, 2'b00);
    check("load_exit_ctrl", ctrl, C_T0);

    // Fixed-length variant: NOP runs all six steps
    rst_n0 = 1'b0;
    @(negedge clk);
    #2;
    rst_n0 = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("fixed_t%0d", k), t_state0, k % 6);
      if (k % 6 >= 2) check($sformatf("fixed_ctrl%0d", k), ctrl0, C_IDLE);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
